// File: rtl/ps2_ctrl_pkg.sv
// Shared types and constants for the PS2 keyboard controller.
//   state_e      : controller FSM states
//   key_event_t  : one folded key event {extended, released, code}
//   PS2_*        : protocol byte values used by the controller
package ps2_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] PS2_EXT    = 8'hE0;
  localparam logic [BYTE_W-1:0] PS2_BRK    = 8'hF0;
  localparam logic [BYTE_W-1:0] PS2_ACK    = 8'hFA;
  localparam logic [BYTE_W-1:0] PS2_RESEND = 8'hFE;

  typedef enum logic [1:0] {
    ST_LISTEN   = 2'd0,
    ST_SEND     = 2'd1,
    ST_ACK_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  // 'release' is a reserved word, so the break flag is named 'released'
  typedef struct packed {
    logic              extended;
    logic              released;
    logic [BYTE_W-1:0] code;
  } key_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead synchronous FIFO of key events.
//   clk, reset_n : clock, async active-low reset
//   push_i/data_i: write request and event (ignored when full unless popping)
//   pop_i        : read request (ignored when empty)
//   full_o/empty_o: occupancy flags
//   head_o       : oldest entry, read straight from storage
module ps2_event_fifo
  import ps2_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_i,
  input  key_event_t data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output key_event_t head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  key_event_t             mem_q [DEPTH];
  logic       [PTR_W-1:0] wr_ptr_q;
  logic       [PTR_W-1:0] rd_ptr_q;
  logic       [CNT_W-1:0] count_q;

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the slot a same-cycle push needs, so full+pop+push succeeds
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage, pointers (wrap naturally on power-of-2 depth) and count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_controller.sv
// PS2 keyboard controller: keeps the receiver armed, folds E0/F0 prefixes
// into key events queued in a FIFO, and runs one host command at a time
// through the transmitter with response timeout and resend handling.
//   cmd_*        : host command handshake (cmd_ready is a 1-cycle pulse)
//   tx_*         : transmitter request/status
//   rx_*         : receiver arm and received-byte strobe
//   key_*        : head of the key-event FIFO (show-ahead), popped by key_ready
//   resp_*       : command completion pulse, response byte and error flag
//   overflow     : sticky FIFO-drop indicator
module ps2_rx_controller
  import ps2_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned ACK_TIMEOUT = 50000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  output logic       tx_send_command,
  output logic [7:0] tx_command_byte,
  input  logic       tx_command_was_sent,
  input  logic       tx_error_timeout,
  output logic       rx_wait_for_incoming_data,
  output logic       rx_start_receiving_data,
  input  logic [7:0] rx_data,
  input  logic       rx_data_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  input  logic       key_ready,
  output logic       resp_valid,
  output logic [7:0] resp_byte,
  output logic       resp_error,
  output logic       overflow
);

  localparam int unsigned TIMER_W = $clog2(ACK_TIMEOUT) + 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  state_e               state_q,       state_d;
  logic                 ext_q,         ext_d;
  logic                 brk_q,         brk_d;
  logic [7:0]           cmd_byte_q,    cmd_byte_d;
  logic [RETRY_W-1:0]   retry_q,       retry_d;
  logic [TIMER_W-1:0]   timer_q,       timer_d;
  logic                 cmd_ready_q,   cmd_ready_d;
  logic                 tx_send_q,     tx_send_d;
  logic                 rx_wait_q,     rx_wait_d;
  logic                 resp_valid_q,  resp_valid_d;
  logic [7:0]           resp_byte_q,   resp_byte_d;
  logic                 resp_error_q,  resp_error_d;
  logic                 overflow_q,    overflow_d;

  logic       push_c;
  logic       pop_c;
  logic       fifo_full;
  logic       fifo_empty;
  key_event_t push_event;
  key_event_t head_event;

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_c),
    .data_i  (push_event),
    .pop_i   (pop_c),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_event)
  );

  assign pop_c = key_ready && !fifo_empty;

  // Next-state, counters and registered-output inputs
  always_comb begin
    state_d      = state_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    cmd_byte_d   = cmd_byte_q;
    retry_d      = retry_q;
    timer_d      = timer_q;
    cmd_ready_d  = 1'b0;
    resp_byte_d  = resp_byte_q;
    resp_error_d = resp_error_q;
    push_c       = 1'b0;
    push_event   = '{extended: ext_q, released: brk_q, code: rx_data};

    case (state_q)
      ST_LISTEN: begin
        if (rx_data_en) begin
          if (rx_data == PS2_EXT) begin
            ext_d = 1'b1;
          end else if (rx_data == PS2_BRK) begin
            brk_d = 1'b1;
          end else begin
            push_c = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
        end else if (cmd_valid && !ext_q && !brk_q) begin
          // Only start a command between complete scan sequences
          cmd_ready_d = 1'b1;
          cmd_byte_d  = cmd_byte;
          retry_d     = '0;
          state_d     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (tx_command_was_sent) begin
          timer_d = '0;
          state_d = ST_ACK_WAIT;
        end else if (tx_error_timeout) begin
          resp_byte_d  = 8'h00;
          resp_error_d = 1'b1;
          state_d      = ST_DONE;
        end
      end

      ST_ACK_WAIT: begin
        // A byte on the final timer cycle takes priority over the timeout
        if (rx_data_en) begin
          if (rx_data == PS2_RESEND) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = ST_SEND;
            end else begin
              resp_byte_d  = PS2_RESEND;
              resp_error_d = 1'b1;
              state_d      = ST_DONE;
            end
          end else begin
            resp_byte_d  = rx_data;
            resp_error_d = 1'b0;
            state_d      = ST_DONE;
          end
        end else if (timer_q == TIMER_LAST) begin
          resp_byte_d  = 8'h00;
          resp_error_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_LISTEN;
      end

      default: begin
        state_d = ST_LISTEN;
      end
    endcase

    // Outputs are registered off the next state so they align with it
    tx_send_d    = (state_d == ST_SEND);
    rx_wait_d    = (state_d == ST_LISTEN) || (state_d == ST_ACK_WAIT);
    resp_valid_d = (state_d == ST_DONE);
    overflow_d   = overflow_q || (push_c && fifo_full && !pop_c);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_LISTEN;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      cmd_byte_q   <= '0;
      retry_q      <= '0;
      timer_q      <= '0;
      cmd_ready_q  <= 1'b0;
      tx_send_q    <= 1'b0;
      rx_wait_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_byte_q  <= '0;
      resp_error_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      cmd_byte_q   <= cmd_byte_d;
      retry_q      <= retry_d;
      timer_q      <= timer_d;
      cmd_ready_q  <= cmd_ready_d;
      tx_send_q    <= tx_send_d;
      rx_wait_q    <= rx_wait_d;
      resp_valid_q <= resp_valid_d;
      resp_byte_q  <= resp_byte_d;
      resp_error_q <= resp_error_d;
      overflow_q   <= overflow_d;
    end
  end

  assign cmd_ready                 = cmd_ready_q;
  assign tx_send_command           = tx_send_q;
  assign tx_command_byte           = cmd_byte_q;
  assign rx_wait_for_incoming_data = rx_wait_q;
  assign rx_start_receiving_data   = 1'b0;
  assign resp_valid                = resp_valid_q;
  assign resp_byte                 = resp_byte_q;
  assign resp_error                = resp_error_q;
  assign overflow                  = overflow_q;

  // Show-ahead view of the FIFO head
  assign key_valid    = !fifo_empty;
  assign key_code     = head_event.code;
  assign key_extended = head_event.extended;
  assign key_release  = head_event.released;

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Directed self-checking bench for ps2_rx_controller.
module tb_ps2_rx_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       cmd_ready;
  logic       tx_send_command;
  logic [7:0] tx_command_byte;
  logic       tx_command_was_sent;
  logic       tx_error_timeout;
  logic       rx_wait_for_incoming_data;
  logic       rx_start_receiving_data;
  logic [7:0] rx_data;
  logic       rx_data_en;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_release;
  logic       key_ready;
  logic       resp_valid;
  logic [7:0] resp_byte;
  logic       resp_error;
  logic       overflow;

  int vectors = 0;
  int errors  = 0;
  int sends   = 0;

  always #5 clk = ~clk;

  ps2_rx_controller #(
    .FIFO_DEPTH  (8),
    .ACK_TIMEOUT (40),
    .MAX_RETRY   (2)
  ) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .cmd_valid                 (cmd_valid),
    .cmd_byte                  (cmd_byte),
    .cmd_ready                 (cmd_ready),
    .tx_send_command           (tx_send_command),
    .tx_command_byte           (tx_command_byte),
    .tx_command_was_sent       (tx_command_was_sent),
    .tx_error_timeout          (tx_error_timeout),
    .rx_wait_for_incoming_data (rx_wait_for_incoming_data),
    .rx_start_receiving_data   (rx_start_receiving_data),
    .rx_data                   (rx_data),
    .rx_data_en                (rx_data_en),
    .key_valid                 (key_valid),
    .key_code                  (key_code),
    .key_extended              (key_extended),
    .key_release               (key_release),
    .key_ready                 (key_ready),
    .resp_valid                (resp_valid),
    .resp_byte                 (resp_byte),
    .resp_error                (resp_error),
    .overflow                  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data    = b;
    rx_data_en = 1'b1;
    tick();
    rx_data_en = 1'b0;
  endtask

  task automatic sent_pulse();
    tx_command_was_sent = 1'b1;
    tick();
    tx_command_was_sent = 1'b0;
  endtask

  task automatic pop();
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
  endtask

  task automatic issue_cmd(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_byte  = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset_n             = 1'b0;
    cmd_valid           = 1'b0;
    cmd_byte            = 8'h00;
    tx_command_was_sent = 1'b0;
    tx_error_timeout    = 1'b0;
    rx_data             = 8'h00;
    rx_data_en          = 1'b0;
    key_ready           = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_tx_send", tx_send_command, 0);
    chk("rst_rx_wait", rx_wait_for_incoming_data, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rx_start_tied", rx_start_receiving_data, 0);
    reset_n = 1'b1;
    tick();
    chk("listen_rx_wait", rx_wait_for_incoming_data, 1);

    // Plain make code
    rx_byte(8'h1C);
    chk("k1_valid", key_valid, 1);
    chk("k1_code", key_code, 8'h1C);
    chk("k1_ext", key_extended, 0);
    chk("k1_rel", key_release, 0);
    pop();
    chk("k1_popped", key_valid, 0);

    // E0 F0 75 folds into one event
    rx_byte(8'hE0);
    chk("e0_no_event", key_valid, 0);
    rx_byte(8'hF0);
    chk("f0_no_event", key_valid, 0);
    rx_byte(8'h75);
    chk("k2_valid", key_valid, 1);
    chk("k2_code", key_code, 8'h75);
    chk("k2_ext", key_extended, 1);
    chk("k2_rel", key_release, 1);
    pop();
    chk("k2_popped", key_valid, 0);

    // Command ED acknowledged with FA
    issue_cmd(8'hED);
    chk("ed_ready", cmd_ready, 1);
    chk("ed_send", tx_send_command, 1);
    chk("ed_byte", tx_command_byte, 8'hED);
    chk("ed_rx_off", rx_wait_for_incoming_data, 0);
    tick();
    chk("ed_ready_pulse", cmd_ready, 0);
    chk("ed_send_hold", tx_send_command, 1);
    sent_pulse();
    chk("ed_send_drop", tx_send_command, 0);
    chk("ed_ackwait_rx", rx_wait_for_incoming_data, 1);
    rx_byte(8'hFA);
    chk("ed_resp_valid", resp_valid, 1);
    chk("ed_resp_byte", resp_byte, 8'hFA);
    chk("ed_resp_err", resp_error, 0);
    chk("ed_fifo_untouched", key_valid, 0);
    tick();
    chk("ed_resp_pulse", resp_valid, 0);
    chk("ed_resp_hold", resp_byte, 8'hFA);

    // Resend handling: three FE replies exhaust MAX_RETRY=2
    issue_cmd(8'h42);
    if (tx_send_command) sends++;
    for (int i = 0; i < 3; i++) begin
      sent_pulse();
      chk("rs_send_drop", tx_send_command, 0);
      rx_byte(8'hFE);
      if (i < 2) begin
        chk("rs_resend", tx_send_command, 1);
        if (tx_send_command) sends++;
      end else begin
        chk("rs_final_send", tx_send_command, 0);
        chk("rs_resp_valid", resp_valid, 1);
        chk("rs_resp_err", resp_error, 1);
        chk("rs_resp_byte", resp_byte, 8'hFE);
      end
    end
    chk("rs_send_count", sends, 3);
    chk("rs_fifo_untouched", key_valid, 0);
    tick();

    // No response: timeout after ACK_TIMEOUT=40 cycles in ACK_WAIT
    issue_cmd(8'h55);
    sent_pulse();
    repeat (39) tick();
    chk("to_not_yet", resp_valid, 0);
    tick();
    chk("to_resp_valid", resp_valid, 1);
    chk("to_resp_err", resp_error, 1);
    chk("to_resp_byte", resp_byte, 8'h00);
    tick();

    // Transmitter error
    issue_cmd(8'hF3);
    tx_error_timeout = 1'b1;
    tick();
    tx_error_timeout = 1'b0;
    chk("txe_resp_valid", resp_valid, 1);
    chk("txe_resp_err", resp_error, 1);
    chk("txe_resp_byte", resp_byte, 8'h00);
    tick();

    // Command held off while an E0 prefix is pending
    rx_byte(8'hE0);
    cmd_valid = 1'b1;
    cmd_byte  = 8'hF4;
    tick();
    chk("hold_ready_0", cmd_ready, 0);
    tick();
    chk("hold_send_0", tx_send_command, 0);
    rx_byte(8'h74);
    chk("hold_ready_1", cmd_ready, 0);
    chk("hold_key_code", key_code, 8'h74);
    chk("hold_key_ext", key_extended, 1);
    chk("hold_key_rel", key_release, 0);
    tick();
    cmd_valid = 1'b0;
    chk("hold_accept", cmd_ready, 1);
    chk("hold_send", tx_send_command, 1);
    chk("hold_byte", tx_command_byte, 8'hF4);
    sent_pulse();
    rx_byte(8'hFA);
    chk("hold_resp", resp_byte, 8'hFA);
    tick();
    pop();
    chk("hold_popped", key_valid, 0);

    // Overflow: nine events into an eight-deep FIFO
    for (int i = 0; i < 9; i++) begin
      rx_byte(8'h10 + 8'(i));
      if (i == 7) chk("ov_not_yet", overflow, 0);
    end
    chk("ov_set", overflow, 1);
    for (int i = 0; i < 8; i++) begin
      chk("ov_order_valid", key_valid, 1);
      chk("ov_order_code", key_code, 32'h10 + 32'(i));
      pop();
    end
    chk("ov_drained", key_valid, 0);
    rx_byte(8'h2A);
    chk("ov_sticky", overflow, 1);

    // Asynchronous reset in the middle of SEND
    issue_cmd(8'hEE);
    chk("ar_send", tx_send_command, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_send_clr", tx_send_command, 0);
    chk("ar_fifo_empty", key_valid, 0);
    chk("ar_overflow_clr", overflow, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("ar_listen", rx_wait_for_incoming_data, 1);
    chk("ar_idle_send", tx_send_command, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_controller.md
Name: ps2_rx_controller

Overview:
Sequences the PS2 receive datapath and the PS2 command transmitter for a keyboard.
- Keeps the receiver listening when idle.
- Arbitrates one host command at a time onto the transmitter, then collects the device response with timeout and resend handling.
- Folds E0/F0 prefix bytes into single key events, buffered in a small FIFO for downstream game logic.

Parameters:
FIFO_DEPTH, 8, key-event FIFO entries (power of 2, >=2)
ACK_TIMEOUT, 50000, clk cycles allowed for the device response after a command is sent
MAX_RETRY, 2, resends issued after receiving 0xFE before the command fails

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host requests a command byte be sent
cmd_byte  in  8  command byte
cmd_ready  out  1  command accepted this cycle (1-cycle pulse)
tx_send_command  out  1  held high to make the transmitter send tx_command_byte
tx_command_byte  out  8  byte to transmit
tx_command_was_sent  in  1  transmitter done pulse
tx_error_timeout  in  1  transmitter failed pulse
rx_wait_for_incoming_data  out  1  receiver arm (listen for device start bit)
rx_start_receiving_data  out  1  tied 0; the controller never forces receive mid-frame
rx_data  in  8  received byte
rx_data_en  in  1  received-byte strobe (1 cycle)
key_valid  out  1  FIFO non-empty
key_code  out  8  head event scan code
key_extended  out  1  head event had E0 prefix
key_release  out  1  head event had F0 prefix
key_ready  in  1  pop head when key_valid
resp_valid  out  1  command finished (1-cycle pulse)
resp_byte  out  8  last response byte (0x00 on timeout)
resp_error  out  1  qualifies resp_valid: timeout, transmit error or retries exhausted
overflow  out  1  sticky: event dropped because FIFO full; cleared only by reset

Behaviour:
- Reset (async, reset_n=0): FSM to LISTEN, prefix flags cleared, FIFO emptied, retry and timeout counters 0. Every output is 0 except rx_wait_for_incoming_data=1 after the first clock.
- FSM states: LISTEN, SEND, ACK_WAIT, DONE.
- LISTEN: rx_wait_for_incoming_data=1.
  - Byte in: 0xE0 sets ext; 0xF0 sets brk; any other byte pushes {ext, brk, byte} and clears both flags. Push is 1 cycle after rx_data_en.
  - Command acceptance: cmd_valid is accepted (cmd_ready pulse, byte latched, retry=0, go to SEND) only when rx_data_en=0 and both flags are clear. This keeps a command from interrupting a multi-byte scan sequence. On a simultaneous rx byte, the byte wins and the command waits.
- SEND: tx_send_command=1, rx_wait_for_incoming_data=0.
  - tx_command_was_sent: drop send, clear timer, go to ACK_WAIT.
  - tx_error_timeout: go to DONE with resp_error=1, resp_byte=0x00.
- ACK_WAIT: rx_wait_for_incoming_data=1; timer increments every cycle.
  - 0xFA or any non-0xFE byte: resp_byte=byte, error=0, go to DONE.
  - 0xFE with retry<MAX_RETRY: retry++, go to SEND.
  - 0xFE with retry=MAX_RETRY: go to DONE with error=1, resp_byte=0xFE.
  - Timer reaching ACK_TIMEOUT-1 without a byte: go to DONE, error=1, resp_byte=0x00.
  - A byte arriving on the timeout cycle wins over the timeout.
  - Bytes received in ACK_WAIT never enter the FIFO.
- DONE: resp_valid pulse for 1 cycle, then LISTEN. resp_byte and resp_error hold until the next DONE.
- FIFO:
  - Show-ahead: key_* outputs reflect the head combinationally from storage.
  - Pop when key_valid && key_ready.
  - Push with FIFO full and no pop in the same cycle: event dropped, overflow set.
  - Simultaneous push and pop when full: both succeed.
  - Pointers wrap modulo FIFO_DEPTH; count is width log2(FIFO_DEPTH)+1.
- Timer width is clog2(ACK_TIMEOUT)+1 and saturates at the compare. Retry counter width is clog2(MAX_RETRY+1).

Decomposition:
- Package ps2_ctrl_pkg:
  - FSM state enum.
  - Byte constants PS2_EXT=0xE0, PS2_BRK=0xF0, PS2_ACK=0xFA, PS2_RESEND=0xFE.
  - Key-event struct {extended, release, code[7:0]}.
- Sub-module ps2_event_fifo: parameterised synchronous FIFO, same clk/reset_n, with push/pop/full/empty/head.

Test Plan:
- Reset then byte 0x1C -> 1 cycle later key_valid=1, key_code=0x1C, ext=0, rel=0; pop with key_ready -> key_valid=0.
- Bytes E0, F0, 0x75 -> exactly one event: code=0x75, extended=1, release=1; no events for the prefix bytes.
- cmd_byte=0xED accepted -> tx_send_command high until tx_command_was_sent; rx 0xFA -> resp_valid pulse, resp_byte=0xFA, resp_error=0; FIFO unchanged.
- Command, then 0xFE three times with MAX_RETRY=2 -> two resends observed (send asserted 3 times total), then resp_error=1, resp_byte=0xFE.
- Command sent, no response for ACK_TIMEOUT cycles -> resp_valid with resp_error=1, resp_byte=0x00. Also cmd_valid asserted during E0 pending -> cmd_ready withheld until the following non-prefix byte completes.
- Push 9 events with FIFO_DEPTH=8 and key_ready=0 -> 8 entries retained in order, overflow=1. Assert reset_n=0 mid-SEND -> tx_send_command=0 immediately, FIFO empty, overflow=0.
